// File: rtl/quadrature_generator_if.sv
// quadrature_generator_if: command, abort and quadrature output bundle of the encoder emulator.
interface quadrature_generator_if #(
    parameter int CNT_W = 8,
    parameter int POS_W = 4
);
    logic             cmd_valid;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;
    logic             abort;
    logic             out_a;
    logic             out_b;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    modport master (
        output cmd_valid, cmd_dir, cmd_count, abort,
        input  cmd_ready, out_a, out_b, busy, done, position
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_count, abort,
        output cmd_ready, out_a, out_b, busy, done, position
    );
endinterface

// File: rtl/quadrature_generator.sv
// quadrature_generator: emits N detents of 4-phase Gray code on out_a/out_b at a fixed phase rate.
module quadrature_generator #(
    parameter int PHASE_CYCLES = 1000,
    parameter int CNT_W        = 8,
    parameter int POS_W        = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    quadrature_generator_if.slave bus
);
    localparam int TW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [1:0]       phase;
    logic [1:0]       nxt_phase;
    logic             dir;
    logic             abort_q;
    logic [CNT_W-1:0] remaining;

    assign nxt_phase = phase + 2'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            timer         <= '0;
            phase         <= '0;
            dir           <= 1'b0;
            abort_q       <= 1'b0;
            remaining     <= '0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.out_a     <= 1'b0;
            bus.out_b     <= 1'b0;
            bus.position  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        dir           <= bus.cmd_dir;
                        remaining     <= bus.cmd_count;
                        phase         <= '0;
                        timer         <= RELOAD;
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_count == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    abort_q <= abort_q | bus.abort;
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer     <= RELOAD;
                        phase     <= nxt_phase;
                        // CW leads with A, CCW leads with B; phase 0 is always 00
                        bus.out_a <= dir ? nxt_phase[1] : nxt_phase[1] ^ nxt_phase[0];
                        bus.out_b <= dir ? nxt_phase[1] ^ nxt_phase[0] : nxt_phase[1];
                        if (phase == 2'd3) begin
                            bus.position <= dir ? bus.position - POS_W'(1) : bus.position + POS_W'(1);
                            remaining    <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1) || abort_q || bus.abort) begin
                                state    <= DONE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    abort_q       <= 1'b0;
                    bus.done      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quadrature_generator.sv
// tb_quadrature_generator: directed commands with an edge/done scoreboard checked on the falling clock edge.
module tb_quadrature_generator;
    localparam int PC = 4;

    typedef struct {
        logic [1:0] ab;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_asrt = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    bit   mon_en = 1'b1;
    exp_t eq[$];
    int   dq[$];
    logic [1:0] cw_seq[4];
    logic [1:0] ccw_seq[4];

    quadrature_generator_if #(.CNT_W(8), .POS_W(4)) q ();

    quadrature_generator #(.PHASE_CYCLES(PC), .CNT_W(8), .POS_W(4)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (q.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input bit d, input int n, input int a);
        for (int i = 0; i < n; i++)
            for (int p = 1; p <= 4; p++)
                eq.push_back('{d ? ccw_seq[p-1] : cw_seq[p-1], a + (i * 4 + p) * PC});
        dq.push_back(a + n * 4 * PC);
    endtask

    task automatic send(input bit d, input int n, input bit push, output int a);
        int k = 0;
        while (!q.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_send", q.cmd_ready, 1);
        q.cmd_valid = 1'b1;
        q.cmd_dir   = d;
        q.cmd_count = 8'(n);
        @(posedge clk);
        #1;
        a = cyc;
        if (push) push_cmd(d, n, a);
        q.cmd_valid = 1'b0;
        chk("ready_after_accept", q.cmd_ready, 0);
        chk("busy_after_accept", q.busy, n != 0);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", done_seen, target);
        @(negedge clk);
    endtask

    initial begin
        int a;
        int a2;
        bit done_hi;
        cw_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
        ccw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        q.cmd_valid = 1'b0;
        q.cmd_dir   = 1'b0;
        q.cmd_count = '0;
        q.abort     = 1'b0;
        fork
            forever @(posedge clk) cyc++;
            begin
                logic [1:0] prev = 2'b00;
                logic [1:0] cur;
                exp_t e;
                int d;
                forever begin
                    @(negedge clk);
                    cur = {q.out_a, q.out_b};
                    if (mon_en && cur !== prev) begin
                        e = eq.size() != 0 ? eq.pop_front() : '{2'bxx, -1};
                        chk("edge_ab", cur, e.ab);
                        chk("edge_cyc", cyc, e.cyc);
                        chk("edge_one_bit", $countones(cur ^ prev), 1);
                    end
                    if (mon_en && q.done) begin
                        d = dq.size() != 0 ? dq.pop_front() : -1;
                        chk("done_cyc", cyc, d);
                        done_seen++;
                    end
                    prev = cur;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_out_a", q.out_a, 0);
        chk("rst_out_b", q.out_b, 0);
        chk("rst_ready", q.cmd_ready, 1);
        chk("rst_busy", q.busy, 0);
        chk("rst_done", q.done, 0);
        chk("rst_position", q.position, 0);

        send(1'b0, 3, 1'b1, a);
        wait_done(1, 100);
        chk("cw3_position", q.position, 3);
        chk("cw3_idle_out", {q.out_a, q.out_b}, 0);
        chk("cw3_busy", q.busy, 0);

        send(1'b1, 2, 1'b1, a);
        wait_done(2, 100);
        chk("ccw2_position", q.position, 1);

        send(1'b0, 14, 1'b1, a);
        wait_done(3, 300);
        chk("cw14_position", q.position, 15);
        send(1'b0, 1, 1'b1, a);
        wait_done(4, 50);
        chk("wrap_up_position", q.position, 0);
        send(1'b1, 1, 1'b1, a);
        wait_done(5, 50);
        chk("wrap_down_position", q.position, 15);

        q.abort = 1'b1;
        send(1'b0, 0, 1'b1, a);
        wait_done(6, 10);
        chk("zero_position", q.position, 15);
        q.abort = 1'b0;
        send(1'b0, 1, 1'b1, a);
        wait_done(7, 50);
        chk("idle_abort_ignored_position", q.position, 0);

        send(1'b0, 5, 1'b0, a);
        push_cmd(1'b0, 2, a);
        while (cyc < a + 25) @(negedge clk);
        q.abort = 1'b1;
        @(negedge clk);
        q.abort = 1'b0;
        wait_done(8, 100);
        chk("abort_position", q.position, 2);
        chk("abort_out", {q.out_a, q.out_b}, 0);

        send(1'b0, 1, 1'b1, a);
        q.cmd_valid = 1'b1;
        q.cmd_dir   = 1'b1;
        q.cmd_count = 8'd2;
        a2 = a + 4 * PC + 2;
        push_cmd(1'b1, 2, a2);
        while (cyc < a2) @(negedge clk);
        q.cmd_valid = 1'b0;
        wait_done(10, 100);
        chk("held_valid_position", q.position, 1);

        mon_en = 1'b0;
        send(1'b0, 3, 1'b0, a);
        while (cyc < a + 2 * PC + 1) @(negedge clk);
        chk("pre_reset_out", {q.out_a, q.out_b}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_out", {q.out_a, q.out_b}, 0);
        chk("async_rst_position", q.position, 0);
        chk("async_rst_ready", q.cmd_ready, 1);
        chk("async_rst_busy", q.busy, 0);
        done_hi = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            done_hi |= q.done;
        end
        chk("no_done_after_reset", done_hi, 0);

        chk("edge_queue_empty", eq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
